// File: rtl/t20_bottle_intake_ctrl_pkg.sv
// Shared types and default constants for the bottle intake controller.
package t20_pkg;
   localparam int COUNT_W_DEF         = 3;
   localparam int BIN_CAP_DEF         = 7;
   localparam int REWARD_EVERY_DEF    = 3;
   localparam int DEBOUNCE_CYCLES_DEF = 4;

   typedef enum logic [2:0] {
      IDLE, DEBOUNCE, CLASSIFY, ACCEPT, REJECT, REWARD, WAIT_CLEAR, FULL
   } state_t;
endpackage

// File: rtl/t20_bottle_intake_ctrl_if.sv
// Front-panel / dispenser signal bundle for the intake controller.
// reject_count exists only when T20_REJECT_COUNT_EN is defined.
interface t20_bottle_intake_ctrl_if #(parameter int COUNT_W = t20_pkg::COUNT_W_DEF);
   logic               item_detect;
   logic               item_is_plastic;
   logic               reward_ack;
   logic               bin_emptied;
   logic [COUNT_W-1:0] plastic_count;
   logic               door_open;
   logic               accept_pulse;
   logic               reject;
   logic               reward_req;
   logic               bin_full;
`ifdef T20_REJECT_COUNT_EN
   logic [COUNT_W-1:0] reject_count;
`endif

   modport master (
      output item_detect, item_is_plastic, reward_ack, bin_emptied,
      input  plastic_count, door_open, accept_pulse, reject, reward_req, bin_full
`ifdef T20_REJECT_COUNT_EN
      , input reject_count
`endif
   );

   modport slave (
      input  item_detect, item_is_plastic, reward_ack, bin_emptied,
      output plastic_count, door_open, accept_pulse, reject, reward_req, bin_full
`ifdef T20_REJECT_COUNT_EN
      , output reject_count
`endif
   );
endinterface

// File: rtl/t20_bottle_intake_ctrl_debounce.sv
// Consecutive-high qualifier: qual strobes on the sample that completes CYCLES highs.
module t20_debounce #(
   parameter int CYCLES = t20_pkg::DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic din,
   output logic qual
);
   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] cnt;

   assign qual = en && din && (cnt == CW'(CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!rst)                     cnt <= '0;
      else if (!en || !din || qual) cnt <= '0;
      else                          cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/t20_bottle_intake_ctrl.sv
// Bottle intake sequencer: debounce, classify, count, reward and bin-full lockout.
// Optional reject counter enabled by defining T20_REJECT_COUNT_EN.
module t20_bottle_intake_ctrl
   import t20_pkg::*;
#(
   parameter int COUNT_W         = COUNT_W_DEF,
   parameter int BIN_CAP         = BIN_CAP_DEF,
   parameter int REWARD_EVERY    = REWARD_EVERY_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input logic                     clk,
   input logic                     rst,
   t20_bottle_intake_ctrl_if.slave bus
);
   localparam int TW = $clog2(REWARD_EVERY) + 1;

   state_t             state, state_nxt;
   logic [COUNT_W-1:0] count, count_nxt, count_inc;
   logic [TW-1:0]      tally, tally_nxt;
   logic               deb_en, qual, reward_due;

   assign deb_en     = (state == IDLE) || (state == DEBOUNCE);
   assign count_inc  = (count == COUNT_W'(BIN_CAP)) ? count : count + COUNT_W'(1);
   assign reward_due = (tally == TW'(REWARD_EVERY - 1));

   t20_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk  (clk),
      .rst  (rst),
      .en   (deb_en),
      .din  (bus.item_detect),
      .qual (qual)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         tally <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
         tally <= tally_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      tally_nxt = tally;
      case (state)
         IDLE:       if (qual) state_nxt = CLASSIFY;
                     else if (bus.item_detect) state_nxt = DEBOUNCE;
         DEBOUNCE:   if (!bus.item_detect) state_nxt = IDLE;
                     else if (qual) state_nxt = CLASSIFY;
         CLASSIFY:   state_nxt = bus.item_is_plastic ? ACCEPT : REJECT;
         ACCEPT: begin
            count_nxt = count_inc;
            // Reward takes priority; FULL is picked up again on REWARD exit.
            if (reward_due) begin
               tally_nxt = '0;
               state_nxt = REWARD;
            end else begin
               tally_nxt = tally + TW'(1);
               state_nxt = (count_inc == COUNT_W'(BIN_CAP)) ? FULL : WAIT_CLEAR;
            end
         end
         REJECT:     if (!bus.item_detect) state_nxt = IDLE;
         REWARD:     if (bus.reward_ack)
                        state_nxt = (count == COUNT_W'(BIN_CAP)) ? FULL : WAIT_CLEAR;
         WAIT_CLEAR: if (!bus.item_detect) state_nxt = IDLE;
         FULL: begin
            if (bus.bin_emptied) begin
               count_nxt = '0;
               state_nxt = WAIT_CLEAR;
            end
         end
         default:    state_nxt = IDLE;
      endcase
   end

   assign bus.plastic_count = count;
   assign bus.accept_pulse  = (state == ACCEPT);
   assign bus.reject        = (state == REJECT);
   assign bus.reward_req    = (state == REWARD);
   assign bus.bin_full      = (state == FULL);
   // Door stays open while an item may still be entering or being pulled back out.
   assign bus.door_open     = (state == IDLE) || (state == DEBOUNCE) ||
                              (state == CLASSIFY) || (state == REJECT);

`ifdef T20_REJECT_COUNT_EN
   logic [COUNT_W-1:0] rej_cnt;

   always_ff @(posedge clk) begin
      if (!rst)
         rej_cnt <= '0;
      else if (state == FULL && bus.bin_emptied)
         rej_cnt <= '0;
      else if (state == CLASSIFY && !bus.item_is_plastic && rej_cnt != '1)
         rej_cnt <= rej_cnt + COUNT_W'(1);
   end

   assign bus.reject_count = rej_cnt;
`endif
endmodule

// File: tb/tb_t20_bottle_intake_ctrl.sv
// Directed bench for t20_bottle_intake_ctrl with an accept/count scoreboard.
module tb_t20_bottle_intake_ctrl;
   localparam int COUNT_W = 3;
   localparam int BIN_CAP = 7;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   t20_bottle_intake_ctrl_if #(.COUNT_W(COUNT_W)) bus_if ();

   t20_bottle_intake_ctrl #(
      .COUNT_W(COUNT_W), .BIN_CAP(BIN_CAP), .REWARD_EVERY(3), .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int exp_q[$];
   int exp_cnt = 0;
   bit exp_full = 1'b0;
   bit pend = 1'b0;
   int pend_val = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected count is queued when a plastic item is presented and popped on accept_pulse.
   task automatic item_on(input bit plastic);
      bus_if.item_is_plastic = plastic;
      bus_if.item_detect     = 1'b1;
      if (plastic && !exp_full) begin
         exp_cnt++;
         exp_q.push_back(exp_cnt);
         if (exp_cnt == BIN_CAP) exp_full = 1'b1;
      end
      repeat (6) tick();
   endtask

   task automatic item_off();
      bus_if.item_detect     = 1'b0;
      bus_if.item_is_plastic = 1'b0;
      tick();
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bus_if.item_detect = 1'b0;
      bus_if.item_is_plastic = 1'b0;
      bus_if.reward_ack = 1'b0;
      bus_if.bin_emptied = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      exp_cnt = 0;
      exp_full = 1'b0;
      exp_q.delete();
   endtask

   always @(negedge clk) begin
      if (pend) begin
         check("sb_count", bus_if.plastic_count, pend_val);
         pend = 1'b0;
      end
      if (rst && bus_if.accept_pulse === 1'b1) begin
         check("sb_accept_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            pend_val = exp_q.pop_front();
            pend = 1'b1;
         end
      end
   end

   initial begin
      int n;
      // 1: reset and basic accept
      do_reset();
      check("rst_door", bus_if.door_open, 1);
      check("rst_count", bus_if.plastic_count, 0);
      check("rst_accept", bus_if.accept_pulse, 0);
      check("rst_reject", bus_if.reject, 0);
      check("rst_req", bus_if.reward_req, 0);
      check("rst_full", bus_if.bin_full, 0);
      item_on(1'b1);
      check("t1_count", bus_if.plastic_count, 1);
      check("t1_door_closed", bus_if.door_open, 0);
      item_off();
      check("t1_door_open", bus_if.door_open, 1);

      // 2: glitches shorter than the debounce window
      bus_if.item_is_plastic = 1'b1;
      bus_if.item_detect = 1'b1;
      repeat (3) tick();
      bus_if.item_detect = 1'b0;
      tick(); tick();
      for (int i = 0; i < 10; i++) begin
         n = $urandom_range(1, 3);
         bus_if.item_detect = 1'b1;
         repeat (n) tick();
         bus_if.item_detect = 1'b0;
         tick(); tick();
      end
      check("t2_count", bus_if.plastic_count, exp_cnt);

      // 3: non-plastic item, and bin_emptied outside FULL
      item_on(1'b0);
      check("t3_reject", bus_if.reject, 1);
      check("t3_door", bus_if.door_open, 1);
      check("t3_count", bus_if.plastic_count, exp_cnt);
      item_off();
      check("t3_reject_clr", bus_if.reject, 0);
`ifdef T20_REJECT_COUNT_EN
      check("t3_reject_count", bus_if.reject_count, 1);
`endif
      bus_if.bin_emptied = 1'b1;
      tick();
      bus_if.bin_emptied = 1'b0;
      tick();
      check("t3_empty_ignored", bus_if.plastic_count, 1);

      // 4: reward handshake with delayed ack, then tally restart
      do_reset();
      item_on(1'b1); check("t4_req_1", bus_if.reward_req, 0); item_off();
      item_on(1'b1); check("t4_req_2", bus_if.reward_req, 0); item_off();
      item_on(1'b1);
      check("t4_req_rise", bus_if.reward_req, 1);
      check("t4_count", bus_if.plastic_count, 3);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t4_req_held", bus_if.reward_req, 1);
      end
      bus_if.reward_ack = 1'b1;
      tick();
      check("t4_req_drop", bus_if.reward_req, 0);
      tick();
      bus_if.reward_ack = 1'b0;
      item_off();
      item_on(1'b1); check("t4_tally_1", bus_if.reward_req, 0); item_off();
      item_on(1'b1); check("t4_tally_2", bus_if.reward_req, 0); item_off();
      item_on(1'b1); check("t4_tally_3", bus_if.reward_req, 1);
      bus_if.reward_ack = 1'b1;
      tick();
      bus_if.reward_ack = 1'b0;
      item_off();
      check("t4_count6", bus_if.plastic_count, 6);

      // 5: fill to capacity, ignore items while full, then empty
      do_reset();
`ifdef T20_REJECT_COUNT_EN
      item_on(1'b0); item_off();
      check("t5_reject_count", bus_if.reject_count, 1);
`endif
      for (int k = 1; k <= BIN_CAP; k++) begin
         item_on(1'b1);
         check("t5_req", bus_if.reward_req, (k % 3 == 0) ? 1 : 0);
         check("t5_full", bus_if.bin_full, (k == BIN_CAP) ? 1 : 0);
         if (k % 3 == 0) begin
            bus_if.reward_ack = 1'b1;
            tick();
            bus_if.reward_ack = 1'b0;
            check("t5_req_drop", bus_if.reward_req, 0);
         end
         if (k == BIN_CAP) begin
            check("t5_door_full", bus_if.door_open, 0);
            check("t5_count_cap", bus_if.plastic_count, BIN_CAP);
         end
         item_off();
      end
      item_on(1'b1);
      item_off();
      check("t5_full_held", bus_if.bin_full, 1);
      check("t5_count_held", bus_if.plastic_count, BIN_CAP);
      bus_if.bin_emptied = 1'b1;
      tick();
      bus_if.bin_emptied = 1'b0;
      exp_cnt = 0;
      exp_full = 1'b0;
      check("t5_emptied_count", bus_if.plastic_count, 0);
      check("t5_emptied_full", bus_if.bin_full, 0);
`ifdef T20_REJECT_COUNT_EN
      check("t5_reject_count_clr", bus_if.reject_count, 0);
`endif
      tick();
      check("t5_door_reopen", bus_if.door_open, 1);

      // 6: reset while a reward is outstanding
      do_reset();
      item_on(1'b1); item_off();
      item_on(1'b1); item_off();
      item_on(1'b1);
      check("t6_req_before", bus_if.reward_req, 1);
      rst = 1'b0;
      bus_if.item_detect = 1'b0;
      tick();
      check("t6_req_after", bus_if.reward_req, 0);
      check("t6_count_after", bus_if.plastic_count, 0);
      check("t6_door_after", bus_if.door_open, 1);
      rst = 1'b1;
      exp_cnt = 0;
      tick(); tick();

      check("sb_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
